// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MduWidth = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StRun,
    StFix,
    StDone
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide.
// Multiply: acc_i is the running product, operand_i the multiplicand, bit_i the multiplier bit.
// Divide: acc_i is {remainder, quotient}, operand_i the divisor, bit_i the next dividend bit.
module mdu_step #(
  parameter int unsigned Width = 32
) (
  input  logic                 is_div_i,
  input  logic [2*Width-1:0]   acc_i,
  input  logic [Width-1:0]     operand_i,
  input  logic                 bit_i,
  output logic [2*Width-1:0]   acc_o,
  output logic                 q_bit_o
);

  logic [Width:0]   sum;
  logic [Width:0]   trial;
  logic [Width-1:0] diff;
  logic             ge;

  always_comb begin
    sum   = {1'b0, acc_i[2*Width-1:Width]} + (bit_i ? {1'b0, operand_i} : '0);
    trial = {acc_i[2*Width-1:Width], bit_i};
    ge    = trial >= {1'b0, operand_i};
    // When ge holds the true difference is below 2^Width, so the low bits suffice.
    diff  = trial[Width-1:0] - operand_i;
    if (is_div_i) begin
      acc_o   = {(ge ? diff : trial[Width-1:0]), acc_i[Width-2:0], 1'b0};
      q_bit_o = ge;
    end else begin
      acc_o   = {sum, acc_i[Width-1:1]};
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MduWidth,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  mdu_state_e         state_q, state_d;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   opa_q, opb_q;
  logic               sign_a_q, sign_b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dbz_q;

  logic               is_div, is_signed, last_iter;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               q_bit;
  logic [WIDTH-1:0]   step_operand;
  logic               step_bit;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   hi_res, lo_res;

  assign is_div    = op_is_div(op_q);
  assign is_signed = op_is_signed(op_q);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Divide streams the dividend MSB-first; multiply streams the multiplier LSB-first.
  assign step_operand = is_div ? opb_q : opa_q;
  assign step_bit     = is_div ? opa_q[WIDTH-1] : opb_q[0];

  mdu_step #(
    .Width (WIDTH)
  ) u_step (
    .is_div_i  (is_div),
    .acc_i     (acc_q),
    .operand_i (step_operand),
    .bit_i     (step_bit),
    .acc_o     (acc_nxt),
    .q_bit_o   (q_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StPrep;
      StPrep:  state_d = StRun;
      StRun:   if (last_iter) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = start ? StPrep : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy = (state_q == StPrep) || (state_q == StRun) || (state_q == StFix);
    done = (state_q == StDone);
  end

  // Sign and zero-divisor fix-up of the raw iteration result
  always_comb begin
    prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    if (is_div) begin
      if (b_q == '0) begin
        lo_res = '1;
        hi_res = a_q;
      end else begin
        lo_res = (sign_a_q ^ sign_b_q) ? -quot : quot;
        hi_res = sign_a_q ? -rem : rem;
      end
    end else begin
      lo_res = prod[WIDTH-1:0];
      hi_res = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            dbz_q <= 1'b0;
          end
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
        end
        StPrep: begin
          sign_a_q <= is_signed & a_q[WIDTH-1];
          sign_b_q <= is_signed & b_q[WIDTH-1];
          opa_q    <= (is_signed & a_q[WIDTH-1]) ? -a_q : a_q;
          opb_q    <= (is_signed & b_q[WIDTH-1]) ? -b_q : b_q;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        StRun: begin
          acc_q <= {acc_nxt[2*WIDTH-1:1], acc_nxt[0] | q_bit};
          cnt_q <= cnt_q + CNT_W'(1);
          if (is_div) begin
            opa_q <= {opa_q[WIDTH-2:0], 1'b0};
          end else begin
            opb_q <= {1'b0, opb_q[WIDTH-1:1]};
          end
        end
        StFix: begin
          hi_q  <= hi_res;
          lo_q  <= lo_res;
          dbz_q <= is_div && (b_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
